fetch_decode_buffer: RTL
========================

FETCH_DECODE_BUFFER -- requirements
Module: fetch_decode_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of queued entries; power of two, 2..16.
REQ-002 Parameter INIT_WORD, default 32'h0000_0000, value driven on out_instr and out_pc_plus_4 when empty.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  fetch stage presents an instruction this cycle.
REQ-006 in_instr  input  32  fetched instruction word.
REQ-007 in_pc_plus_4  input  32  PC+4 of the fetched instruction.
REQ-008 in_ready  output  1  buffer accepts a push this cycle.
REQ-009 flush  input  1  branch/jump redirect; discard all queued entries.
REQ-010 out_valid  output  1  head entry available to decode.
REQ-011 out_instr  output  32  head instruction word.
REQ-012 out_pc_plus_4  output  32  head PC+4.
REQ-013 out_ready  input  1  decode consumes the head this cycle.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 Buffer SHALL be a circular FIFO, DEPTH entries of {instr, pc_plus_4}, with read/write pointers of $clog2(DEPTH) bits wrapping from DEPTH-1 to 0.
REQ-016 Push SHALL occur when in_valid && in_ready && !flush; pop SHALL occur when out_valid && out_ready && !flush.
REQ-017 in_ready SHALL equal (count < DEPTH); a push into a full buffer is refused even if a pop occurs the same cycle.
REQ-018 out_valid SHALL equal (count != 0), except as amended by REQ-027.
REQ-019 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-020 Push-only SHALL increment count by 1; pop-only SHALL decrement count by 1; count SHALL never exceed DEPTH or go below 0.
REQ-021 Without bypass, latency SHALL be one cycle: an entry pushed in cycle N appears on out_* in cycle N+1.
REQ-022 Entries SHALL be delivered in push order with no duplication or loss.
REQ-023 flush SHALL, at the next edge, set count to 0 and both pointers to 0; a same-cycle push and pop are discarded.
REQ-024 When count == 0, out_instr and out_pc_plus_4 SHALL equal INIT_WORD (and bypass data when REQ-027 applies).

Reset
REQ-025 Asserting reset SHALL immediately clear count and pointers, forcing out_valid=0, in_ready=1, out_instr=out_pc_plus_4=INIT_WORD; storage contents need not be cleared.
REQ-026 Reset asserted mid-operation SHALL discard all entries; the first push after deassertion is the first entry delivered.

Configuration
REQ-027 With FDB_BYPASS_EN defined: when count == 0, in_valid=1, flush=0, out_valid SHALL be 1 and out_* SHALL carry in_* combinationally in the same cycle; if out_ready=1 the entry is consumed without being stored (count stays 0); if out_ready=0 it is stored as a normal push.
REQ-028 Without FDB_BYPASS_EN: no combinational path from in_* to out_*; REQ-021 latency applies always.

Verification
REQ-029 Reset, push 0x2002_0001/0x0000_0004, out_ready=0 -> next cycle out_valid=1, out_instr=0x2002_0001, out_pc_plus_4=0x0000_0004, count=1.
REQ-030 Push 5 words with DEPTH=4, out_ready=0 -> in_ready=0 after 4th, count=4, 5th refused; then pop all -> words 1-4 in order, count=0, out_valid=0.
REQ-031 count=2, push and pop same cycle, repeat 10 cycles -> count stays 2, pointers wrap past 3 to 0, order preserved.
REQ-032 count=3, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, flushed-cycle word never appears.
REQ-033 FDB_BYPASS_EN defined, empty, in_valid=1, out_ready=1, in_instr=0x8C01_0000 -> out_valid=1 and out_instr=0x8C01_0000 same cycle, count remains 0; undefined -> out_valid=0 that cycle, 1 next cycle.
REQ-034 Assert reset asynchronously between edges with count=3 -> out_valid=0, count=0 immediately, before next clk edge.

Source files
------------

// File: rtl/fetch_decode_buffer.sv
// Fetch-to-decode instruction queue: circular FIFO of {instr, pc_plus_4} entries.
// Define FDB_BYPASS_EN to forward a fetch straight to decode when the queue is empty.
module fetch_decode_buffer #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] INIT_WORD = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [31:0]              in_instr,
    input  logic [31:0]              in_pc_plus_4,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc_plus_4,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic empty;
    logic full;
    logic bypass_hit;
    logic push;
    logic pop;
    logic store;
    logic deq;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        in_ready = !full;
`ifdef FDB_BYPASS_EN
        bypass_hit = empty && in_valid && !flush && !reset;
`else
        bypass_hit = 1'b0;
`endif
        out_valid = !empty || bypass_hit;
        push      = in_valid && in_ready && !flush;
        pop       = out_valid && out_ready && !flush;
        // A bypassed entry that decode takes immediately never touches storage.
        store     = push && !(bypass_hit && pop);
        deq       = pop && !bypass_hit;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (store) wr_ptr_d = wr_ptr_q + AW'(1);
            if (deq)   rd_ptr_d = rd_ptr_q + AW'(1);
            case ({store, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left uninitialised; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (store) begin
            instr_mem[wr_ptr_q] <= in_instr;
            pc_mem[wr_ptr_q]    <= in_pc_plus_4;
        end
    end

    always_comb begin
        out_instr     = INIT_WORD;
        out_pc_plus_4 = INIT_WORD;
        if (!empty) begin
            out_instr     = instr_mem[rd_ptr_q];
            out_pc_plus_4 = pc_mem[rd_ptr_q];
        end
`ifdef FDB_BYPASS_EN
        else if (bypass_hit) begin
            out_instr     = in_instr;
            out_pc_plus_4 = in_pc_plus_4;
        end
`endif
    end

    assign count = count_q;

endmodule
